// File: rtl/bsg_manycore_mmio_responder.sv
// Target-side MMIO endpoint: decodes load/store/masked-store requests into a small
// word-addressed register file and returns one tagged response per request, in order.
module bsg_manycore_mmio_responder #(
    parameter int unsigned data_width_p   = 32,
    parameter int unsigned addr_width_p   = 28,
    parameter int unsigned x_cord_width_p = 7,
    parameter int unsigned y_cord_width_p = 7,
    parameter int unsigned els_p          = 16,
    parameter int unsigned fifo_els_p     = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      req_v_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [addr_width_p-1:0]   req_addr_i,
    input  logic [data_width_p-1:0]   req_data_i,
    input  logic [data_width_p/8-1:0] req_mask_i,
    input  logic [x_cord_width_p-1:0] req_src_x_i,
    input  logic [y_cord_width_p-1:0] req_src_y_i,
    input  logic [4:0]                req_reg_id_i,

    output logic                      resp_v_o,
    input  logic                      resp_ready_i,
    output logic [1:0]                resp_type_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [x_cord_width_p-1:0] resp_dest_x_o,
    output logic [y_cord_width_p-1:0] resp_dest_y_o,
    output logic [4:0]                resp_reg_id_o,

    output logic [31:0]               req_count_o,
    output logic [31:0]               err_count_o
);

    localparam int unsigned mask_width_lp = data_width_p / 8;
    localparam int unsigned idx_width_lp  = $clog2(els_p);
    localparam int unsigned ptr_width_lp  = $clog2(fifo_els_p);
    localparam int unsigned cnt_width_lp  = $clog2(fifo_els_p + 1);

    localparam logic [1:0] op_load_lp   = 2'd0;
    localparam logic [1:0] op_store_lp  = 2'd1;
    localparam logic [1:0] op_mstore_lp = 2'd2;
    localparam logic [1:0] op_rsvd_lp   = 2'd3;

    localparam logic [1:0] resp_load_lp = 2'd0;
    localparam logic [1:0] resp_ack_lp  = 2'd1;
    localparam logic [1:0] resp_err_lp  = 2'd2;

    typedef struct packed {
        logic [1:0]                typ;
        logic [data_width_p-1:0]   data;
        logic [x_cord_width_p-1:0] x;
        logic [y_cord_width_p-1:0] y;
        logic [4:0]                reg_id;
    } resp_s;

    logic [data_width_p-1:0] rf_q [els_p];
    resp_s                   fifo_q [fifo_els_p];
    logic [ptr_width_lp-1:0] head_q;
    logic [ptr_width_lp-1:0] tail_q;
    logic [cnt_width_lp-1:0] count_q;
    logic [31:0]             req_count_q;
    logic [31:0]             err_count_q;

    logic                    accept;
    logic                    dequeue;
    logic                    in_range;
    logic                    is_err;
    logic                    wr_en;
    logic [idx_width_lp-1:0] idx;
    logic [data_width_p-1:0] rd_word;
    logic [data_width_p-1:0] wr_word;
    resp_s                   new_resp;
    resp_s                   head_resp;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // No pass-through: readiness only looks at the registered occupancy.
    assign req_ready_o = (count_q < cnt_width_lp'(fifo_els_p));
    assign resp_v_o    = (count_q != '0);
    assign accept      = req_v_i & req_ready_o;
    assign dequeue     = resp_v_o & resp_ready_i;
    assign idx         = req_addr_i[idx_width_lp-1:0];

    // Request decode, merged write word and the response to enqueue.
    always_comb begin
        in_range = (req_addr_i < addr_width_p'(els_p));
        is_err   = !in_range || (req_op_i == op_rsvd_lp);
        rd_word  = rf_q[idx];
        wr_en    = accept && !is_err &&
                   ((req_op_i == op_store_lp) || (req_op_i == op_mstore_lp));
        wr_word  = rd_word;
        for (int unsigned b = 0; b < mask_width_lp; b++) begin
            if ((req_op_i == op_store_lp) || req_mask_i[b]) begin
                wr_word[8*b +: 8] = req_data_i[8*b +: 8];
            end
        end

        new_resp        = '0;
        new_resp.x      = req_src_x_i;
        new_resp.y      = req_src_y_i;
        new_resp.reg_id = req_reg_id_i;
        if (is_err) begin
            new_resp.typ = resp_err_lp;
        end else if (req_op_i == op_load_lp) begin
            new_resp.typ  = resp_load_lp;
            new_resp.data = rd_word;
        end else begin
            new_resp.typ = resp_ack_lp;
        end
    end

    // Register file.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < els_p; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            rf_q[idx] <= wr_word;
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < fifo_els_p; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (accept) begin
            fifo_q[tail_q] <= new_resp;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                tail_q <= ptr_inc(tail_q);
            end
            if (dequeue) begin
                head_q <= ptr_inc(head_q);
            end
            case ({accept, dequeue})
                2'b10:   count_q <= count_q + cnt_width_lp'(1);
                2'b01:   count_q <= count_q - cnt_width_lp'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Request counter wraps; error counter saturates.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (accept) begin
                req_count_q <= req_count_q + 32'd1;
            end
            if (accept && is_err && (err_count_q != '1)) begin
                err_count_q <= err_count_q + 32'd1;
            end
        end
    end

    assign head_resp     = fifo_q[head_q];
    assign resp_type_o   = head_resp.typ;
    assign resp_data_o   = head_resp.data;
    assign resp_dest_x_o = head_resp.x;
    assign resp_dest_y_o = head_resp.y;
    assign resp_reg_id_o = head_resp.reg_id;
    assign req_count_o   = req_count_q;
    assign err_count_o   = err_count_q;

endmodule

// File: doc/bsg_manycore_mmio_responder.md
# bsg_manycore_mmio_responder

Target-side endpoint that answers manycore requests issued by the host I/O complex; it is the responder half of the host request/response path. It decodes load, store and masked-store requests into a small word-addressed register file and returns one response per request (load data, store ack or error). Responses are tagged with the requester's coordinates and reg id so the host DPI endpoint can match them.

## Interface
- data_width_p, 32: request/response data width; must be a multiple of 8.
- addr_width_p, 28: word address width (EPA).
- x_cord_width_p, 7: source/destination X width.
- y_cord_width_p, 7: source/destination Y width.
- els_p, 16: register file words; power of two, at least 2.
- fifo_els_p, 2: response FIFO depth, at least 2.
- clk_i  in  1  core clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
- req_op_i  in  2  0 load, 1 store, 2 masked store, 3 reserved.
- req_addr_i  in  addr_width_p  word address.
- req_data_i  in  data_width_p  store data.
- req_mask_i  in  data_width_p/8  byte enables (op 2 only).
- req_src_x_i / req_src_y_i  in  x_cord_width_p / y_cord_width_p  requester coordinates.
- req_reg_id_i  in  5  requester tag.
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i.
- resp_type_o  out  2  0 load data, 1 store ack, 2 error.
- resp_data_o  out  data_width_p  load data; 0 for ack and error.
- resp_dest_x_o / resp_dest_y_o  out  x/y width  copy of the request source.
- resp_reg_id_o  out  5  copy of req_reg_id_i.
- req_count_o  out  32  accepted requests, wraps.
- err_count_o  out  32  error responses generated, saturates at 2^32-1.

## Operation
- Accept when req_v_i & req_ready_o. req_ready_o = (FIFO count < fifo_els_p). It is combinational from the registered count and does not depend on resp_ready_i, so there is no pass-through when the FIFO is full.
- In range: req_addr_i < els_p. The index is the low clog2(els_p) bits.
- Load, in range: response type 0 with data = the register value before any write on the same edge.
- Store, in range: writes the full word and ignores req_mask_i. Response type 1.
- Masked store, in range: writes only enabled bytes. Response type 1. An all-zero mask still returns an ack and changes no data.
- Out-of-range address or op 3: no write, response type 2 with data 0, err_count_o increments.
- Register file write and response enqueue both occur on the accepting edge.
- The response FIFO is in order, depth fifo_els_p, with head and tail pointers that wrap modulo fifo_els_p.
  - Enqueue on accept; dequeue on resp_v_o & resp_ready_i.
  - If both occur in one cycle, the count is unchanged.
- resp_v_o = (count != 0). Output fields come from the FIFO head and stay stable while resp_v_o & !resp_ready_i.
- req_count_o increments on every accept, including errors.
- Reset, including mid-operation: clears the FIFO and counters, zeroes the register file, and drops pending responses.
  - Out of reset: resp_v_o=0, req_ready_o=1, all resp fields 0, req_count_o=0, err_count_o=0.
  - Requests presented while reset_n_i is low are not accepted into state.

## Timing
- Latency: a request accepted at edge N produces resp_v_o high after edge N (visible in cycle N+1).
- Throughput: one request per cycle sustained when resp_ready_i is held high and fifo_els_p >= 2.
- Read-after-write: a load accepted in the cycle after a store to the same address returns the new value.
- Backpressure: after fifo_els_p accepts with no dequeue, req_ready_o=0. It reasserts in the cycle after the first dequeue.
- Reset assertion takes effect asynchronously. Deassertion is assumed synchronized externally; the first accept is possible on the first clock edge after release.

## Test plan
- Store 0xDEADBEEF to addr 3 from (x=2,y=1,id=5), then load addr 3. Expected responses:
  - type 1 ack to (2,1,5);
  - then type 0, data 0xDEADBEEF, one cycle later;
  - req_count_o=2.
- Masked store of 0x11223344 with mask 0b0101 over 0xAAAAAAAA at addr 0, then load addr 0 -> data 0xAA22AA44.
- Load addr 16 (els_p=16), then issue op 3 -> two type-2 responses with data 0. err_count_o=2 and the register file is unchanged.
- Hold resp_ready_i=0 and issue 3 requests (ids 1,2,3):
  - 2 are accepted; req_ready_o=0 while the third waits.
  - Raise resp_ready_i: responses return in order 1,2,3, and the third is accepted the cycle after the first dequeue.
- Back-to-back loads of addr 0..15 with resp_ready_i=1 -> 16 responses on consecutive cycles with no bubbles.
- Assert reset_n_i with 2 responses queued:
  - resp_v_o drops immediately.
  - After release, req_ready_o=1, both counters are 0, and a load of a previously written address returns 0.
